pipelined_cla_adder: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- Built from 4-bit lookahead groups with group-level generate/propagate and a second lookahead level across groups.
- Valid/ready streaming handshake on both sides with full backpressure.
- Arithmetic primitive for datapath blocks that need widths above 4 bits and a registered, flow-controlled result.

---
 rtl/pipelined_cla_adder.sv | 163 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor: 4-bit lookahead groups plus a lookahead level across groups.
// Latency 2 edges from operand presentation to out_valid; valid/ready on both sides with full backpressure.
// Optional CLA_SAT_EN macro adds a sat input that clamps overflowing results to signed max/min.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    logic adv1, adv2;

    // stage 1 next-state
    logic [WIDTH-1:0] b_eff, p_d, g_d;
    logic [3*NG-1:0]  gl_d;
    logic [NG-1:0]    gg_d, gp_d;
    logic             c0_d;

    // stage 1 registers; bit 3 of each group's g only feeds the group G, so it is not stored
    logic             s1_valid_q;
    logic [WIDTH-1:0] p_q;
    logic [3*NG-1:0]  gl_q;
    logic [NG-1:0]    gg_q, gp_q;
    logic             c0_q;
`ifdef CLA_SAT_EN
    logic             sat_q;
`endif

    // stage 2 next-state and registers
    logic [NG:0]      gcarry;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, ovf_d;
    logic             s2_valid_q, cout_q, ovf_q;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    always_comb begin
        b_eff = b ^ {WIDTH{sub}};
        p_d   = a ^ b_eff;
        g_d   = a & b_eff;
        c0_d  = cin ^ sub;
        gl_d  = '0;
        gg_d  = '0;
        gp_d  = '0;
        for (int k = 0; k < NG; k++) begin
            gl_d[3*k+0] = g_d[4*k+0];
            gl_d[3*k+1] = g_d[4*k+1];
            gl_d[3*k+2] = g_d[4*k+2];
            gg_d[k] = g_d[4*k+3]
                    | (p_d[4*k+3] & g_d[4*k+2])
                    | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                    | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k+0]);
            gp_d[k] = &p_d[4*k +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            gl_q       <= '0;
            gg_q       <= '0;
            gp_q       <= '0;
            c0_q       <= 1'b0;
`ifdef CLA_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q  <= p_d;
                gl_q <= gl_d;
                gg_q <= gg_d;
                gp_q <= gp_d;
                c0_q <= c0_d;
`ifdef CLA_SAT_EN
                sat_q <= sat;
`endif
            end
        end
    end

    // Group carries as flat sum-of-products over G/P, not a ripple chain
    always_comb begin
        gcarry    = '0;
        gcarry[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            logic pr;
            pr = 1'b1;
            for (int j = k; j >= 0; j--) begin
                gcarry[k+1] = gcarry[k+1] | (gg_q[j] & pr);
                pr          = pr & gp_q[j];
            end
            gcarry[k+1] = gcarry[k+1] | (pr & c0_q);
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < NG; k++) begin
            c[4*k+0] = gcarry[k];
            c[4*k+1] = gl_q[3*k+0] | (p_q[4*k+0] & gcarry[k]);
            c[4*k+2] = gl_q[3*k+1]
                     | (p_q[4*k+1] & gl_q[3*k+0])
                     | (p_q[4*k+1] & p_q[4*k+0] & gcarry[k]);
            c[4*k+3] = gl_q[3*k+2]
                     | (p_q[4*k+2] & gl_q[3*k+1])
                     | (p_q[4*k+2] & p_q[4*k+1] & gl_q[3*k+0])
                     | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k+0] & gcarry[k]);
        end
        raw_sum = p_q ^ c;
        cout_d  = gcarry[NG];
        ovf_d   = c[WIDTH-1] ^ gcarry[NG];
        sum_d   = raw_sum;
`ifdef CLA_SAT_EN
        // On overflow the wrapped MSB is the inverse of the common operand sign
        if (sat_q && ovf_d)
            sum_d = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=16): directed vectors, backpressured stream, mid-flight reset.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, ovf;
`ifdef CLA_SAT_EN
    logic        sat;
`endif

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int cnt = 0;
    exp_t exp_cur;
    exp_t sb[$];
    logic held = 1'b0;
    logic [17:0] held_val;

    pipelined_cla_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef CLA_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples pre-edge values, pops expected results in order, checks stalls and in_ready
    always @(posedge clk) begin
        if (rst_n) begin
            logic acc, dlv;
            exp_t got;
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            chk("in_ready", {31'b0, in_ready}, {31'b0, !(cnt == 2 && !out_ready)});
            if (held) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_hold", {14'b0, sum, cout, ovf}, {14'b0, held_val});
            end
            if (dlv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {31'b0, out_valid}, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("result", {14'b0, sum, cout, ovf}, {14'b0, got});
                end
            end
            held     = out_valid && !out_ready;
            held_val = {sum, cout, ovf};
            if (acc) begin
                sb.push_back(exp_cur);
                acc_cnt++;
            end
            cnt = cnt + int'(acc) - int'(dlv);
        end
    end

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
`ifdef CLA_SAT_EN
        sat = v.sat;
`endif
        exp_cur  = v.e;
        in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int n0;
        int t;
        drive(v);
        n0 = acc_cnt;
        t  = 0;
        do begin
            @(negedge clk);
            t++;
        end while (acc_cnt == n0 && t < 50);
        if (acc_cnt == n0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    // {a, b, cin, sub, sat, {sum, cout, ovf}}
    vec_t dir_v[$] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0}},
        '{16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, '{16'h0002, 1'b1, 1'b0}}
`ifdef CLA_SAT_EN
       ,'{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h7FFF, 1'b0, 1'b1}},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, '{16'h8000, 1'b1, 1'b1}}
`endif
    };

    vec_t str_v[8] = '{
        '{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0}},
        '{16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}},
        '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, '{16'hFFFE, 1'b1, 1'b0}},
        '{16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, '{16'h0101, 1'b0, 1'b0}},
        '{16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, '{16'h000F, 1'b1, 1'b0}},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1}},
        '{16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0}}
    };

    logic [9:0] pat = 10'b1011101001;

    initial begin
        int idx;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; exp_cur = '0;
`ifdef CLA_SAT_EN
        sat = 1'b0;
`endif
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir_v[i]) begin
            send(dir_v[i]);
            in_valid = 1'b0;
            drain();
        end

        // Stream with in_valid held high under a fixed out_ready pattern
        idx = 0;
        cyc = 0;
        while ((idx < 8 || sb.size() != 0) && cyc < 300) begin
            int n0;
            out_ready = pat[cyc % 10];
            if (idx < 8) drive(str_v[idx]);
            else in_valid = 1'b0;
            n0 = acc_cnt;
            @(negedge clk);
            if (acc_cnt != n0) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_done", idx, 32'd8);
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(str_v[1]);
        send(str_v[4]);
        in_valid = 1'b0;
        chk("inflight_valid", {31'b0, out_valid}, 32'd1);
        chk("inflight_full", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        cnt  = 0;
        held = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {16'b0, sum}, 32'd0);
        chk("midrst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // First result after release: valid two edges after operands are presented
        drive(dir_v[0]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_sum", {16'b0, sum}, 32'h0100);
        drain();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
